// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one dot-product job through the MAC wrapper.
// A job is a cfg cycle, an enable-framed stream of valid beats, then a
// single read cycle whose captured result is offered on a valid/ready port.
module mac_seq_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_mode,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             mac_enable,
  output logic             mac_valid,
  output logic             mac_read,
  output logic             mac_cfg,
  output logic             mac_mode,
  output logic [15:0]      mac_in_a,
  output logic [15:0]      mac_in_b,
  input  logic [15:0]      mac_out,
  input  logic             mac_error,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_error,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CFG  = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_READ = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [LEN_W-1:0] len_r;
  logic             mode_r;
  logic             err_acc_r;
  logic             res_valid_r;
  logic [15:0]      res_data_r;
  logic             res_error_r;
  logic             beat_s;

  // A beat is accepted only while streaming and the producer offers a pair.
  assign beat_s = (state_r == ST_RUN) && op_valid;

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: READ is entered only once the result slot is free, so a
  // pending result is never overwritten; HOLD keeps the MAC frozen meanwhile.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_s = ST_CFG;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CFG: begin
        if (len_r != LEN_ZERO) begin
          state_s = ST_RUN;
        end else if (res_valid_r) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_RUN: begin
        if (beat_s && (len_r == LEN_ONE)) begin
          if (res_valid_r) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (!res_valid_r) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_READ: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Job context: length countdown, mode, and error accumulated over the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r     <= LEN_ZERO;
      mode_r    <= 1'b0;
      err_acc_r <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && cmd_valid) begin
        len_r     <= cmd_len;
        mode_r    <= cmd_mode;
        err_acc_r <= 1'b0;
      end else begin
        if (beat_s) begin
          len_r <= len_r - LEN_ONE;
        end
        if ((state_r == ST_RUN) || (state_r == ST_HOLD)) begin
          err_acc_r <= err_acc_r | mac_error;
        end
      end
    end
  end

  // Result slot: loaded on READ, held stable until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= 16'd0;
      res_error_r <= 1'b0;
    end else if (state_r == ST_READ) begin
      res_valid_r <= 1'b1;
      res_data_r  <= mac_out;
      res_error_r <= err_acc_r | mac_error;
    end else if (res_valid_r && res_ready) begin
      res_valid_r <= 1'b0;
    end
  end

  // Output decode; enable stays high from the first beat through READ so the
  // MAC never sees enable drop between its last valid and its read.
  always_comb begin
    cmd_ready  = 1'b0;
    op_ready   = 1'b0;
    busy       = 1'b1;
    mac_enable = 1'b0;
    mac_valid  = 1'b0;
    mac_read   = 1'b0;
    mac_cfg    = 1'b0;
    mac_in_a   = 16'd0;
    mac_in_b   = 16'd0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_CFG: begin
        mac_cfg = 1'b1;
      end
      ST_RUN: begin
        op_ready   = 1'b1;
        mac_enable = 1'b1;
        mac_valid  = op_valid;
        mac_in_a   = op_a;
        mac_in_b   = op_b;
      end
      ST_HOLD: begin
        mac_enable = 1'b1;
      end
      ST_READ: begin
        mac_enable = 1'b1;
        mac_read   = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign mac_mode  = mode_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_error = res_error_r;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural MAC accumulator and a
// result scoreboard filled when each job is issued.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_len = 8'd0;
  logic        cmd_mode = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] op_a = 16'd0;
  logic [15:0] op_b = 16'd0;
  logic        mac_enable, mac_valid, mac_read, mac_cfg, mac_mode;
  logic [15:0] mac_in_a, mac_in_b;
  logic [15:0] mac_out;
  logic        mac_error = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_error;
  logic        busy;

  mac_seq_ctrl #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_mode(cmd_mode),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_enable(mac_enable), .mac_valid(mac_valid), .mac_read(mac_read),
    .mac_cfg(mac_cfg), .mac_mode(mac_mode), .mac_in_a(mac_in_a), .mac_in_b(mac_in_b),
    .mac_out(mac_out), .mac_error(mac_error),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_error(res_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: accumulates products, clears on read, reset by rst_n.
  logic [15:0] acc;
  logic [31:0] prod;
  assign prod    = mac_in_a * mac_in_b;
  assign mac_out = acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= 16'd0;
    else if (mac_enable && mac_read) acc <= 16'd0;
    else if (mac_enable && mac_valid) acc <= acc + prod[15:0];
  end

  // Cycle counter and protocol monitor sampled mid-cycle.
  int cyc = 0;
  int cfg_cnt = 0, read_cnt = 0, valid_cnt = 0, opr_cnt = 0;
  int en_drop = 0, cfg_viol = 0, rise_cyc = 0;
  logic in_job = 1'b0, rv_prev = 1'b0, cfg_mode = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mac_cfg) begin
      cfg_cnt  <= cfg_cnt + 1;
      cfg_mode <= mac_mode;
    end
    if (mac_read) read_cnt <= read_cnt + 1;
    if (mac_valid) valid_cnt <= valid_cnt + 1;
    if (op_ready) opr_cnt <= opr_cnt + 1;
    if (mac_cfg && mac_enable) cfg_viol <= cfg_viol + 1;
    rv_prev <= res_valid;
    if (res_valid && !rv_prev) rise_cyc <= cyc;
    if (!rst_n) in_job <= 1'b0;
    else begin
      if (mac_read) in_job <= 1'b0;
      else if (mac_enable) in_job <= 1'b1;
      if (in_job && !mac_enable) en_drop <= en_drop + 1;
    end
  end

  typedef struct { logic [15:0] data; logic err; } exp_t;
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic start_job(input logic [7:0] len, input logic mode);
    int n = 0;
    cmd_len   = len;
    cmd_mode  = mode;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin step(); n++; end
    chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    while (!op_ready && n < 50) begin step(); n++; end
    chk("op_ready", {31'd0, op_ready}, 32'd1);
    step();
    op_valid = 1'b0;
  endtask

  task automatic collect();
    int n = 0;
    exp_t x;
    while (!res_valid && n < 100) begin step(); n++; end
    chk("res_wait", {31'd0, res_valid}, 32'd1);
    chk("sb_size", exp_q.size(), 32'd1 + ((exp_q.size() > 1) ? exp_q.size() - 1 : 0));
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("res_data", {16'd0, res_data}, {16'd0, x.data});
      chk("res_error", {31'd0, res_error}, {31'd0, x.err});
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("res_clear", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_op_ready"}, {31'd0, op_ready}, 32'd0);
    chk({tag, "_mac_ctl"}, {27'd0, mac_enable, mac_valid, mac_read, mac_cfg, mac_mode}, 32'd0);
    chk({tag, "_mac_in"}, {mac_in_a, mac_in_b}, 32'd0);
    chk({tag, "_res"}, {14'd0, res_valid, res_error, res_data}, 32'd0);
  endtask

  int b_valid, b_cfg, b_read, b_opr;

  initial begin
    op_a = 16'h00a5;
    op_b = 16'h005a;
    op_valid = 1'b1;
    step(); step();
    check_idle_outputs("reset");
    op_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Job 1: three (3,4) beats back to back, latency check.
    b_valid = valid_cnt;
    start_job(8'd3, 1'b0);
    push(16'd36, 1'b0);
    chk("cfg_cycle", {31'd0, mac_cfg}, 32'd1);
    send_beat(16'd3, 16'd4);
    send_beat(16'd3, 16'd4);
    send_beat(16'd3, 16'd4);
    collect();
    chk("latency", rise_cyc - acc_cyc, 32'd5);
    chk("valid_beats1", valid_cnt - b_valid, 32'd3);

    // Job 2: two-cycle gaps between beats.
    b_valid = valid_cnt;
    start_job(8'd2, 1'b0);
    push(16'd34, 1'b0);
    send_beat(16'd5, 16'd6);
    step(); step();
    chk("gap_enable", {31'd0, mac_enable}, 32'd1);
    chk("gap_valid", {31'd0, mac_valid}, 32'd0);
    send_beat(16'd2, 16'd2);
    collect();
    chk("valid_beats2", valid_cnt - b_valid, 32'd2);

    // Jobs 3/4: result left pending, second job stalls in HOLD.
    start_job(8'd2, 1'b0);
    push(16'd11, 1'b0);
    send_beat(16'd1, 16'd2);
    send_beat(16'd3, 16'd3);
    step(); step();
    chk("pend_valid", {31'd0, res_valid}, 32'd1);
    start_job(8'd1, 1'b0);
    push(16'd49, 1'b0);
    send_beat(16'd7, 16'd7);
    step(); step(); step();
    chk("hold_busy", {31'd0, busy}, 32'd1);
    chk("hold_ctl", {29'd0, mac_enable, mac_valid, mac_read}, 32'h4);
    chk("hold_data", {16'd0, res_data}, 32'd11);
    collect();
    collect();

    // Zero-length job in fp16 mode.
    b_cfg = cfg_cnt; b_read = read_cnt; b_opr = opr_cnt;
    start_job(8'd0, 1'b1);
    push(16'd0, 1'b0);
    collect();
    chk("zero_cfg", cfg_cnt - b_cfg, 32'd1);
    chk("zero_read", read_cnt - b_read, 32'd1);
    chk("zero_opr", opr_cnt - b_opr, 32'd0);
    chk("zero_mode", {31'd0, cfg_mode}, 32'd1);

    // Error on one RUN cycle, then a clean job.
    start_job(8'd4, 1'b0);
    push(16'd4, 1'b1);
    send_beat(16'd1, 16'd1);
    mac_error = 1'b1;
    send_beat(16'd1, 16'd1);
    mac_error = 1'b0;
    send_beat(16'd1, 16'd1);
    send_beat(16'd1, 16'd1);
    collect();
    start_job(8'd1, 1'b0);
    push(16'd6, 1'b0);
    send_beat(16'd2, 16'd3);
    collect();

    // Reset in the middle of a four-beat job.
    start_job(8'd4, 1'b0);
    send_beat(16'd2, 16'd2);
    send_beat(16'd2, 16'd2);
    op_a = 16'd9;
    op_b = 16'd9;
    op_valid = 1'b1;
    chk("pre_rst_valid", {31'd0, mac_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    step();
    op_valid = 1'b0;
    rst_n = 1'b1;
    step();
    start_job(8'd1, 1'b0);
    push(16'd1, 1'b0);
    send_beat(16'd1, 16'd1);
    collect();

    chk("cfg_isolation", cfg_viol, 32'd0);
    chk("enable_drop", en_drop, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
